// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO constants and Gray/binary pointer helpers
package fifo_pkg;

    localparam int FIFO_ADDR_W  = 8;
    localparam int FIFO_PTR_MAX = 32;

    typedef logic [FIFO_PTR_MAX-1:0] fifo_vec_t;

    // Helpers work on a zero-extended vector, so any pointer width up to FIFO_PTR_MAX
    // converts correctly; callers cast in and truncate out.
    function automatic fifo_vec_t bin2gray(input fifo_vec_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic fifo_vec_t gray2bin(input fifo_vec_t g);
        fifo_vec_t b;
        b[FIFO_PTR_MAX-1] = g[FIFO_PTR_MAX-1];
        for (int i = FIFO_PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray-to-binary pointer converter
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int W = FIFO_ADDR_W + 1
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    fifo_vec_t bin_full;

    always_comb begin
        bin_full = gray2bin(FIFO_PTR_MAX'(gray));
    end

    assign bin = bin_full[W-1:0];

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// rtl/fifo_wptr_ctrl.sv - async FIFO write pointer, full/almost-full/level flags
// Optional sticky overflow flag enabled by FIFO_WR_OVF_EN.
module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int width     = FIFO_ADDR_W,
    parameter int AF_THRESH = (1 << width) - 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [width:0]   wq2_rptr,
    output logic             wen,
    output logic [width-1:0] waddr,
    output logic [width:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [width:0]   wlevel
`ifdef FIFO_WR_OVF_EN
    ,
    output logic             wovf,
    input  logic             wovf_clr
`endif
);

    localparam int PW = width + 1;
    localparam logic [width:0] AF_LVL = PW'(AF_THRESH);

    logic [width:0] wbin_q, wbin_d;
    logic [width:0] wptr_q, wptr_d;
    logic [width:0] wlevel_q, wlevel_d;
    logic [width:0] rbin;
    logic           wfull_q, wfull_d;
    logic           walmost_full_q, walmost_full_d;
    logic           acc;
    fifo_vec_t      wgray_full;

    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // Flags are computed from the next pointer so they are registered alongside it.
    always_comb begin
        acc            = winc & ~wfull_q;
        wbin_d         = wbin_q + {{width{1'b0}}, acc};
        wgray_full     = bin2gray(FIFO_PTR_MAX'(wbin_d));
        wptr_d         = wgray_full[width:0];
        wfull_d        = (wptr_d == {~wq2_rptr[width:width-1], wq2_rptr[width-2:0]});
        wlevel_d       = wbin_d - rbin;
        walmost_full_d = (wlevel_d >= AF_LVL);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
        end
    end

    assign wen          = acc;
    assign waddr        = wbin_q[width-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;

`ifdef FIFO_WR_OVF_EN
    logic wovf_q, wovf_d;

    // Set has priority over clear in the same cycle.
    always_comb begin
        wovf_d = (winc & wfull_q) | (wovf_q & ~wovf_clr);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wovf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
        end
    end

    assign wovf = wovf_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb/tb_fifo_wptr_ctrl.sv - randomized self-checking bench for fifo_wptr_ctrl
module tb_fifo_wptr_ctrl;

    localparam int W     = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;

    logic         wclk = 1'b0;
    logic         wrst_n = 1'b0;
    logic         winc = 1'b0;
    logic [W:0]   wq2_rptr = '0;
    logic         wen;
    logic [W-1:0] waddr;
    logic [W:0]   wptr;
    logic         wfull;
    logic         walmost_full;
    logic [W:0]   wlevel;
    logic         wovf;
    logic         wovf_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: unbounded write/read counts
    int m_wr = 0;
    int m_rd = 0;
    bit m_full = 0;
    bit m_af = 0;
    bit m_ovf = 0;
    int hist[$];

    fifo_wptr_ctrl #(.width(W), .AF_THRESH(AF)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel)
`ifdef FIFO_WR_OVF_EN
        ,
        .wovf         (wovf),
        .wovf_clr     (wovf_clr)
`endif
    );

`ifndef FIFO_WR_OVF_EN
    assign wovf = 1'b0;
`endif

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] gray_of(input int n);
        logic [W:0] b;
        b = (W+1)'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic check_regs();
        chk("wptr", 32'(wptr), 32'(gray_of(m_wr)));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("walmost_full", 32'(walmost_full), 32'(m_af));
        chk("wlevel", 32'(wlevel), 32'(m_wr - m_rd));
`ifdef FIFO_WR_OVF_EN
        chk("wovf", 32'(wovf), 32'(m_ovf));
`endif
    endtask

    // One write-clock cycle: inputs driven after negedge, outputs checked at next negedge.
    task automatic cycle(input bit inc, input int rd, input bit clr);
        bit acc;
        winc     = inc;
        wq2_rptr = gray_of(rd);
        wovf_clr = clr;
        #1;
        acc = inc && !m_full;
        chk("wen", 32'(wen), 32'(acc));
        chk("waddr", 32'(waddr), 32'(m_wr % DEPTH));
        @(posedge wclk);
`ifdef FIFO_WR_OVF_EN
        if (inc && m_full) m_ovf = 1;
        else if (clr) m_ovf = 0;
`endif
        if (acc) m_wr++;
        m_rd   = rd;
        m_full = (m_wr - m_rd) == DEPTH;
        m_af   = (m_wr - m_rd) >= AF;
        @(negedge wclk);
        check_regs();
    endtask

    task automatic do_reset();
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wq2_rptr = '0;
        wovf_clr = 1'b0;
        @(posedge wclk);
        m_wr = 0; m_rd = 0; m_full = 0; m_af = 0; m_ovf = 0;
        @(negedge wclk);
        check_regs();
        chk("rst_waddr", 32'(waddr), 32'd0);
        wrst_n = 1'b1;
        winc   = 1'b0;
    endtask

    initial begin
        @(negedge wclk);
        do_reset();

        // Fill to full with the reader idle, then one refused write
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
        chk("full_lvl16", 32'(wlevel), 32'd16);
        cycle(1, 0, 0);
        chk("wptr_hold", 32'(wptr), 32'b11000);

        // Reader frees one slot; next write lands at address 0
        cycle(0, 1, 0);
        chk("free_lvl15", 32'(wlevel), 32'd15);
        cycle(1, 1, 0);

        // Streaming with read pointer lagging three cycles
        do_reset();
        hist.delete();
        for (int i = 0; i < 40; i++) begin
            cycle(1, (hist.size() >= 3) ? hist[hist.size()-3] : 0, 0);
            hist.push_back(m_wr);
        end

        // Overflow: two refused writes, hold, set+clear together, then clear
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // Reset mid-stream at level 9
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1, 0, 0);
        chk("lvl9", 32'(wlevel), 32'd9);
        do_reset();

        // Random traffic with a legal, monotonic read pointer
        for (int i = 0; i < 400; i++) begin
            int room, step;
            room = m_wr - m_rd;
            step = $urandom_range(0, (room < 2) ? room : 2);
            cycle(1'($urandom_range(0, 3) != 0), m_rd + step, 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
